// File: rtl/mem_port_arbiter.sv
// Two-requester (cpu/debug) round-robin arbiter in front of a single-port data memory.
// One transaction at a time: IDLE -> ACCESS (WAIT_CYCLES cycles) -> RESP (ack) -> IDLE.
module mem_port_arbiter #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_stall,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [15:0] dbg_addr,
  input  logic [15:0] dbg_wdata,
  output logic [15:0] dbg_rdata,
  output logic        dbg_ack,
  output logic        mem_en,
  output logic        mem_rdm,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned DATA_W = 16;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic GNT_CPU = 1'b0;
  localparam logic GNT_DBG = 1'b1;

  logic [1:0]        state,      state_nxt;
  logic [CNT_W-1:0]  cnt,        cnt_nxt;
  logic              last_grant, last_grant_nxt;
  logic              gnt,        gnt_nxt;
  logic              lat_we,     lat_we_nxt;
  logic              mem_en_nxt, mem_rdm_nxt;
  logic [DATA_W-1:0] mem_addr_nxt, mem_wdata_nxt;
  logic [DATA_W-1:0] cpu_rdata_nxt, dbg_rdata_nxt;
  logic              cpu_ack_nxt, dbg_ack_nxt;

  // Stall is the only combinational output: it must drop in the ack cycle itself.
  assign cpu_stall = cpu_req & ~cpu_ack;

  // State register; memory-facing outputs are registered from next-state values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      last_grant <= GNT_DBG;
      gnt        <= GNT_CPU;
      lat_we     <= 1'b0;
      mem_en     <= 1'b0;
      mem_rdm    <= 1'b1;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_rdata  <= '0;
      dbg_rdata  <= '0;
      cpu_ack    <= 1'b0;
      dbg_ack    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      last_grant <= last_grant_nxt;
      gnt        <= gnt_nxt;
      lat_we     <= lat_we_nxt;
      mem_en     <= mem_en_nxt;
      mem_rdm    <= mem_rdm_nxt;
      mem_addr   <= mem_addr_nxt;
      mem_wdata  <= mem_wdata_nxt;
      cpu_rdata  <= cpu_rdata_nxt;
      dbg_rdata  <= dbg_rdata_nxt;
      cpu_ack    <= cpu_ack_nxt;
      dbg_ack    <= dbg_ack_nxt;
    end
  end

  // Next-state and next-output logic; memory is idle/read-direction unless ACCESS follows.
  always_comb begin
    state_nxt      = state;
    cnt_nxt        = cnt;
    last_grant_nxt = last_grant;
    gnt_nxt        = gnt;
    lat_we_nxt     = lat_we;
    mem_en_nxt     = 1'b0;
    mem_rdm_nxt    = 1'b1;
    mem_addr_nxt   = mem_addr;
    mem_wdata_nxt  = mem_wdata;
    cpu_rdata_nxt  = cpu_rdata;
    dbg_rdata_nxt  = dbg_rdata;
    cpu_ack_nxt    = 1'b0;
    dbg_ack_nxt    = 1'b0;

    case (state)
      S_IDLE: begin
        if (cpu_req || dbg_req) begin
          // Tie goes to whoever was not granted last; otherwise the lone requester.
          gnt_nxt        = (cpu_req && dbg_req) ? ~last_grant : dbg_req;
          last_grant_nxt = gnt_nxt;
          lat_we_nxt     = (gnt_nxt == GNT_DBG) ? dbg_we    : cpu_we;
          mem_addr_nxt   = (gnt_nxt == GNT_DBG) ? dbg_addr  : cpu_addr;
          mem_wdata_nxt  = (gnt_nxt == GNT_DBG) ? dbg_wdata : cpu_wdata;
          cnt_nxt        = CNT_W'(WAIT_CYCLES - 1);
          mem_en_nxt     = 1'b1;
          mem_rdm_nxt    = ~lat_we_nxt;
          state_nxt      = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt == '0) begin
          state_nxt = S_RESP;
          if (gnt == GNT_DBG) begin
            dbg_ack_nxt = 1'b1;
            if (!lat_we) dbg_rdata_nxt = mem_rdata;
          end else begin
            cpu_ack_nxt = 1'b1;
            if (!lat_we) cpu_rdata_nxt = mem_rdata;
          end
        end else begin
          cnt_nxt     = cnt - CNT_W'(1);
          mem_en_nxt  = 1'b1;
          mem_rdm_nxt = ~lat_we;
        end
      end
      S_RESP: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance at WAIT_CYCLES=1 (u_dut1), one at 3 (u_dut3).
// Both share stimulus; each scenario checks only the instance it targets.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [15:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata, mem_rdata;

  logic [15:0] cpu_rdata1, dbg_rdata1, mem_addr1, mem_wdata1;
  logic        cpu_ack1, cpu_stall1, dbg_ack1, mem_en1, mem_rdm1;
  logic [15:0] cpu_rdata3, dbg_rdata3, mem_addr3, mem_wdata3;
  logic        cpu_ack3, cpu_stall3, dbg_ack3, mem_en3, mem_rdm3;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.WAIT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata1), .cpu_ack(cpu_ack1), .cpu_stall(cpu_stall1),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata1), .dbg_ack(dbg_ack1),
    .mem_en(mem_en1), .mem_rdm(mem_rdm1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
    .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata3), .cpu_ack(cpu_ack3), .cpu_stall(cpu_stall3),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_rdata(dbg_rdata3), .dbg_ack(dbg_ack3),
    .mem_en(mem_en3), .mem_rdm(mem_rdm3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Advance one clock; inputs are driven and outputs sampled at the falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] cpu_pat, dbg_pat;
    logic [4:0]  en_pat, ack_pat;
    int          lat, acks;

    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
    mem_rdata = '0;
    @(negedge clk);
    do_reset();

    // Reset values
    check("rst_mem_en",    32'(mem_en1),    32'd0);
    check("rst_mem_rdm",   32'(mem_rdm1),   32'd1);
    check("rst_mem_addr",  32'(mem_addr1),  32'd0);
    check("rst_mem_wdata", 32'(mem_wdata1), 32'd0);
    check("rst_rdata",     32'({cpu_rdata1, dbg_rdata1}), 32'd0);
    check("rst_acks",      32'({cpu_ack1, dbg_ack1, cpu_ack3, dbg_ack3}), 32'd0);
    tick();

    // W=1 cpu read addr 19, mem returns 5
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'd19; mem_rdata = 16'd5;
    #1;
    check("rd_stall_c0", 32'(cpu_stall1), 32'd1);
    tick();
    check("rd_access", 32'({mem_en1, mem_rdm1, cpu_ack1, cpu_stall1}), 32'b1101);
    check("rd_addr",   32'(mem_addr1), 32'd19);
    tick();
    check("rd_resp",   32'({mem_en1, cpu_ack1, cpu_stall1}), 32'b010);
    check("rd_rdata",  32'(cpu_rdata1), 32'd5);
    cpu_req = 1'b0;
    tick();
    check("rd_ack_one", 32'(cpu_ack1), 32'd0);

    // W=1 cpu write addr 22 data 9; rdata must keep 5
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'd22; cpu_wdata = 16'd9; mem_rdata = 16'hBEEF;
    tick();
    check("wr_access", 32'({mem_en1, mem_rdm1}), 32'b10);
    check("wr_bus",    32'({mem_addr1, mem_wdata1}), {16'd22, 16'd9});
    tick();
    check("wr_ack",    32'(cpu_ack1), 32'd1);
    check("wr_rdata",  32'(cpu_rdata1), 32'd5);
    cpu_req = 1'b0; cpu_we = 1'b0;
    tick();
    check("wr_idle_hold", 32'({mem_en1, mem_rdm1, mem_addr1, mem_wdata1[12:0]}),
          32'({1'b0, 1'b1, 16'd22, 13'd9}));

    // W=1 both requesting from reset: cpu, dbg, cpu, dbg, every 3 cycles
    cpu_req = 1'b1; dbg_req = 1'b1; cpu_addr = 16'd1; dbg_addr = 16'd2;
    do_reset();
    cpu_pat = '0; dbg_pat = '0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      cpu_pat[i] = cpu_ack1;
      dbg_pat[i] = dbg_ack1;
      if (i == 1) check("rr_addr_first",  32'(mem_addr1), 32'd1);
      if (i == 4) check("rr_addr_second", 32'(mem_addr1), 32'd2);
    end
    cpu_req = 1'b0; dbg_req = 1'b0;
    check("rr_cpu_acks",  32'(cpu_pat), 32'h0104);
    check("rr_dbg_acks",  32'(dbg_pat), 32'h0820);
    check("rr_no_overlap", 32'(cpu_pat & dbg_pat), 32'd0);

    // W=3: give cpu_rdata a value, then a dbg read must not touch it
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'd3; mem_rdata = 16'd7;
    for (int i = 0; i < 10 && !cpu_ack3; i++) tick();
    check("w3_cpu_ack",   32'(cpu_ack3), 32'd1);
    check("w3_cpu_rdata", 32'(cpu_rdata3), 32'd7);
    cpu_req = 1'b0;
    tick();
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 16'd25; mem_rdata = 16'd2;
    en_pat = '0; ack_pat = '0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      en_pat[i]  = mem_en3;
      ack_pat[i] = dbg_ack3;
      if (i == 1) check("w3_dbg_addr", 32'({mem_addr3, 15'd0, mem_rdm3}), {16'd25, 16'd1});
    end
    dbg_req = 1'b0;
    check("w3_en_pat",    32'(en_pat),  32'b01110);
    check("w3_ack_pat",   32'(ack_pat), 32'b10000);
    check("w3_dbg_rdata", 32'(dbg_rdata3), 32'd2);
    check("w3_cpu_keep",  32'(cpu_rdata3), 32'd7);
    tick();

    // W=3 write aborted by reset in its 2nd ACCESS cycle
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'd40; cpu_wdata = 16'h55;
    tick();
    check("ab_access1", 32'({mem_en3, mem_rdm3}), 32'b10);
    tick();
    rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0;
    tick();
    check("ab_after_rst", 32'({mem_en3, mem_rdm3, cpu_ack3, dbg_ack3}), 32'b0100);
    acks = 0;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      acks += int'(cpu_ack3) + int'(dbg_ack3) + int'(mem_en3);
    end
    check("ab_quiet", 32'(acks), 32'd0);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'd50; mem_rdata = 16'h33;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!cpu_ack3 && lat < 10);
    check("ab_next_latency", 32'(lat), 32'd4);
    check("ab_next_rdata",   32'(cpu_rdata3), 32'h33);
    cpu_req = 1'b0;
    tick();

    // W=3 addr/we changed and req dropped after grant
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'd60; mem_rdata = 16'h44;
    tick();
    check("chg_addr_c1", 32'(mem_addr3), 32'd60);
    cpu_req = 1'b0; cpu_addr = 16'd61; cpu_we = 1'b1; cpu_wdata = 16'h99;
    acks = 0;
    for (int i = 2; i <= 8; i++) begin
      tick();
      if (i == 2) check("chg_addr_c2", 32'({mem_addr3, 15'd0, mem_rdm3}), {16'd60, 16'd1});
      acks += int'(cpu_ack3);
    end
    check("chg_one_ack", 32'(acks), 32'd1);
    check("chg_rdata",   32'(cpu_rdata3), 32'h44);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
